// File: rtl/gcd_arbiter.sv
// Round-robin front end that time-shares one subtractive GCD core between NREQ requesters.
// Zero operands bypass the core; a watchdog aborts runs that never report done.
module gcd_arbiter #(
  parameter int WIDTH  = 8,
  parameter int NREQ   = 2,
  parameter int MAXCYC = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_x_i,
  input  logic [NREQ*WIDTH-1:0] req_y_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  input  logic [NREQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  gcd_rst_o,
  output logic                  gcd_start_o,
  output logic [WIDTH-1:0]      gcd_x_o,
  output logic [WIDTH-1:0]      gcd_y_o,
  input  logic                  gcd_done_i,
  input  logic [WIDTH-1:0]      gcd_result_i,
  output logic                  busy_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MAXCYC > 1) ? $clog2(MAXCYC + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(MAXCYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   rr_ptr, rr_ptr_next;
  logic [PW-1:0]   grant, grant_next;
  logic [WIDTH-1:0] gcd_x, gcd_x_next, gcd_y, gcd_y_next;
  logic [WIDTH-1:0] data, data_next;
  logic            err, err_next;
  logic [CW-1:0]   wd, wd_next;

  logic [PW-1:0]   cand [NREQ];
  logic [WIDTH-1:0] x_arr [NREQ];
  logic [WIDTH-1:0] y_arr [NREQ];
  logic [PW-1:0]   pick;
  logic            found;
  logic [WIDTH-1:0] x_sel, y_sel;

  // cand[gi] is the requester index at offset gi from the round-robin pointer.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
    assign cand[gi]  = PW'((int'(rr_ptr) + gi) % NREQ);
    assign x_arr[gi] = req_x_i[gi*WIDTH +: WIDTH];
    assign y_arr[gi] = req_y_i[gi*WIDTH +: WIDTH];
  end

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[cand[i]]) begin
        found = 1'b1;
        pick  = cand[i];
      end
    end
    x_sel = x_arr[pick];
    y_sel = y_arr[pick];
  end

  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
    grant_next  = grant;
    gcd_x_next  = gcd_x;
    gcd_y_next  = gcd_y;
    data_next   = data;
    err_next    = err;
    wd_next     = wd;
    req_ready_o = '0;
    rsp_valid_o = '0;
    gcd_start_o = 1'b0;
    gcd_rst_o   = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          req_ready_o[pick] = 1'b1;
          grant_next        = pick;
          gcd_x_next        = x_sel;
          gcd_y_next        = y_sel;
          if (x_sel == '0 || y_sel == '0) begin
            data_next  = x_sel | y_sel;
            err_next   = 1'b0;
            state_next = RESP;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        gcd_start_o = 1'b1;
        wd_next     = '0;
        state_next  = WAIT;
      end
      WAIT: begin
        // done is checked first so a result arriving on the timeout cycle is kept
        if (gcd_done_i) begin
          data_next  = gcd_result_i;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (wd == WD_LAST) begin
          gcd_rst_o  = 1'b1;
          data_next  = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          wd_next = wd + 1'b1;
        end
      end
      RESP: begin
        rsp_valid_o[grant] = 1'b1;
        if (rsp_ready_i[grant]) begin
          rr_ptr_next = (grant == PW'(NREQ - 1)) ? '0 : grant + 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      gcd_x  <= '0;
      gcd_y  <= '0;
      data   <= '0;
      err    <= 1'b0;
      wd     <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
      grant  <= grant_next;
      gcd_x  <= gcd_x_next;
      gcd_y  <= gcd_y_next;
      data   <= data_next;
      err    <= err_next;
      wd     <= wd_next;
    end
  end

  assign gcd_x_o    = gcd_x;
  assign gcd_y_o    = gcd_y;
  assign rsp_data_o = data;
  assign rsp_err_o  = err;
  assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter: vector table plus hand-written sequences for
// watchdog abort, held response, mid-run reset and round-robin alternation.
module tb_gcd_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready_o;
  logic [15:0] req_x = '0;
  logic [15:0] req_y = '0;
  logic [1:0]  rsp_valid_o;
  logic [1:0]  rsp_ready = '0;
  logic [7:0]  rsp_data_o;
  logic        rsp_err_o;
  logic        gcd_rst_o;
  logic        gcd_start_o;
  logic [7:0]  gcd_x_o;
  logic [7:0]  gcd_y_o;
  logic        core_done;
  logic [7:0]  core_res;
  logic        busy_o;

  gcd_arbiter #(.WIDTH(8), .NREQ(2), .MAXCYC(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_x_i(req_x), .req_y_i(req_y),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .gcd_rst_o(gcd_rst_o), .gcd_start_o(gcd_start_o),
    .gcd_x_o(gcd_x_o), .gcd_y_o(gcd_y_o),
    .gcd_done_i(core_done), .gcd_result_i(core_res),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, q, t;
    p = a;
    q = b;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Core model: done pulses core_lat cycles after the start pulse, unless disabled.
  bit  core_en = 1'b1;
  int  core_lat = 5;
  int  core_cnt;
  bit  core_busy;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_busy <= 1'b0;
      core_done <= 1'b0;
      core_cnt  <= 0;
      core_res  <= '0;
    end else begin
      core_done <= 1'b0;
      if (gcd_rst_o) begin
        core_busy <= 1'b0;
      end else if (gcd_start_o) begin
        core_busy <= core_en;
        core_cnt  <= core_lat;
        core_res  <= gcd_ref(gcd_x_o, gcd_y_o);
      end else if (core_busy) begin
        if (core_cnt <= 1) begin
          core_done <= 1'b1;
          core_busy <= 1'b0;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  int cyc = 0, start_cnt = 0, start_cyc = 0, rst_cnt = 0, rst_cyc = 0;
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (gcd_start_o) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (gcd_rst_o) begin
      rst_cnt <= rst_cnt + 1;
      rst_cyc <= cyc;
    end
  end

  typedef struct {
    int         k;
    logic [7:0] x;
    logic [7:0] y;
    int         lat;
    logic [7:0] exp_data;
    bit         bypass;
  } vec_t;

  vec_t vecs[8];
  int   txn_no = 0;

  task automatic run_txn(input int k, input logic [7:0] x, input logic [7:0] y, input int lat,
                         input logic [7:0] exp_data, input logic exp_err, input bit bypass);
    int n;
    int s0;
    logic [1:0] onehot;
    onehot   = 2'(1 << k);
    core_lat = lat;
    s0       = start_cnt;
    @(posedge clk_i); #1;
    req_valid[k]       = 1'b1;
    req_x[k*8 +: 8]    = x;
    req_y[k*8 +: 8]    = y;
    n = 0;
    @(negedge clk_i);
    while (req_ready_o != onehot && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check("accept", 32'(req_ready_o), 32'(onehot));
    @(posedge clk_i); #1;
    req_valid[k] = 1'b0;
    n = 1;
    @(negedge clk_i);
    while (rsp_valid_o == 0 && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    check("rsp_valid", 32'(rsp_valid_o), 32'(onehot));
    check("rsp_data", 32'(rsp_data_o), 32'(exp_data));
    check("rsp_err", 32'(rsp_err_o), 32'(exp_err));
    if (bypass) check("bypass_latency", n, 1);
    check("start_pulses", start_cnt - s0, bypass ? 0 : 1);
    @(posedge clk_i); #1;
    rsp_ready[k] = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready[k] = 1'b0;
    @(negedge clk_i);
    check("busy_after_rsp", 32'(busy_o), 0);
    $display("txn %0d: req%0d x=%0d y=%0d -> data=%0d err=%0d latency=%0d",
             txn_no, k, x, y, rsp_data_o, rsp_err_o, n);
    txn_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation hung");
  end

  initial begin
    int n;
    int r0;
    logic [1:0] g;

    vecs[0] = '{k: 0, x: 8'd12,  y: 8'd8,  lat: 5, exp_data: 8'd4,  bypass: 1'b0};
    vecs[1] = '{k: 1, x: 8'd0,   y: 8'd35, lat: 5, exp_data: 8'd35, bypass: 1'b1};
    vecs[2] = '{k: 1, x: 8'd0,   y: 8'd0,  lat: 5, exp_data: 8'd0,  bypass: 1'b1};
    vecs[3] = '{k: 0, x: 8'd9,   y: 8'd6,  lat: 3, exp_data: 8'd3,  bypass: 1'b0};
    vecs[4] = '{k: 1, x: 8'd21,  y: 8'd14, lat: 7, exp_data: 8'd7,  bypass: 1'b0};
    vecs[5] = '{k: 0, x: 8'd35,  y: 8'd0,  lat: 5, exp_data: 8'd35, bypass: 1'b1};
    vecs[6] = '{k: 1, x: 8'd255, y: 8'd17, lat: 1, exp_data: 8'd17, bypass: 1'b0};
    vecs[7] = '{k: 0, x: 8'd13,  y: 8'd7,  lat: 4, exp_data: 8'd1,  bypass: 1'b0};

    // Reset state
    #1;
    check("reset_outputs",
          {req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, gcd_rst_o, gcd_start_o, gcd_x_o, gcd_y_o, busy_o}, 0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    foreach (vecs[i])
      run_txn(vecs[i].k, vecs[i].x, vecs[i].y, vecs[i].lat, vecs[i].exp_data, 1'b0, vecs[i].bypass);

    // Held response: rsp_ready low for 10 cycles, non-granted ready toggling
    @(posedge clk_i); #1;
    req_valid[1] = 1'b1; req_x[15:8] = 8'd0; req_y[15:8] = 8'd20;
    @(posedge clk_i); #1;
    req_valid[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rsp_ready[0] = ~rsp_ready[0];
      @(negedge clk_i);
      check("hold_valid", 32'({rsp_valid_o, busy_o}), 32'(3'b101));
      check("hold_data", 32'({rsp_err_o, rsp_data_o}), 32'd20);
      @(posedge clk_i); #1;
    end
    rsp_ready = 2'b10;
    @(posedge clk_i); #1;
    rsp_ready = 2'b00;
    @(negedge clk_i);
    check("hold_release_busy", 32'(busy_o), 0);
    $display("txn %0d: req1 held response 10 cycles, data=20", txn_no);
    txn_no++;

    // Watchdog abort with a silent core
    core_en = 1'b0;
    r0 = rst_cnt;
    run_txn(0, 8'd10, 8'd4, 5, 8'd0, 1'b1, 1'b0);
    check("wd_rst_pulses", rst_cnt - r0, 1);
    check("wd_rst_cycle", rst_cyc - start_cyc, 15);
    core_en = 1'b1;

    // Reset during WAIT; pointer currently favours req1
    core_lat = 20;
    @(posedge clk_i); #1;
    req_valid[0] = 1'b1; req_x[7:0] = 8'd12; req_y[7:0] = 8'd8;
    @(posedge clk_i); #1;
    req_valid[0] = 1'b0;
    n = 0;
    @(negedge clk_i);
    while (!gcd_start_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    check("rst_test_start", 32'(gcd_start_o), 1);
    repeat (3) @(negedge clk_i);
    check("busy_before_rst", 32'(busy_o), 1);
    rst_ni = 1'b0;
    #1;
    check("mid_run_reset_outputs",
          {req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, gcd_rst_o, gcd_start_o, gcd_x_o, gcd_y_o, busy_o}, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    $display("txn %0d: req0 aborted by reset during WAIT", txn_no);
    txn_no++;

    // Both requesters held valid: grants must alternate starting at req0
    core_lat = 2;
    @(posedge clk_i); #1;
    req_valid = 2'b11;
    req_x = {8'd9, 8'd9};
    req_y = {8'd6, 8'd6};
    for (int t = 0; t < 4; t++) begin
      n = 0;
      @(negedge clk_i);
      while (req_ready_o == 0 && n < 40) begin
        @(negedge clk_i);
        n++;
      end
      g = req_ready_o;
      check("rr_grant", 32'(g), (t % 2 == 0) ? 32'd1 : 32'd2);
      n = 0;
      @(negedge clk_i);
      while (rsp_valid_o == 0 && n < 40) begin
        @(negedge clk_i);
        n++;
      end
      check("rr_rsp_valid", 32'(rsp_valid_o), 32'(g));
      check("rr_rsp_data", 32'(rsp_data_o), 32'd3);
      $display("txn %0d: round-robin grant=%b data=%0d", txn_no, g, rsp_data_o);
      txn_no++;
      @(posedge clk_i); #1;
      rsp_ready = g;
      @(posedge clk_i); #1;
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    repeat (6) @(posedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
